// File: rtl/watchdog_ctrl.sv
// watchdog_ctrl: register front end and key-sequence FSM for a watchdog core.
//
// Software arms the watchdog through CTRL, then services it with the two-step
// key sequence 0xA5 / 0x5A written to KEY. A wrong key, an illegal write while
// the first key is pending, or a core timeout raises sys_reset_req for 16
// cycles; the block then sits in HALT until reset_n.
//
// Register map (address): 0x08 CTRL, 0x09 STATUS, 0x0a TIMER, 0x0b KEY,
// 0x0c WINDOW. Unmapped addresses read 0 and ignore writes.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   cs, we, address,      single-cycle register access; read when we is low
//   write_data
//   read_data, ready      registered read result, ready high the cycle after cs
//   core_start/core_stop  one-cycle control pulses to the watchdog core
//   core_timer_init       reload value taken from TIMER
//   core_running,         status inputs from the watchdog core
//   core_timeout
//   sys_reset_req         system reset request (16 cycles long)
//
// Build option: define WATCHDOG_WINDOW_EN to add the windowed-kick check
// (elapsed counter vs WINDOW). Without it WINDOW reads 0 and kicks are always
// accepted.

module watchdog_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        core_start,
  output logic        core_stop,
  output logic [27:0] core_timer_init,
  input  logic        core_running,
  input  logic        core_timeout,
  output logic        sys_reset_req
);

  localparam logic [7:0]  AddrCtrl   = 8'h08;
  localparam logic [7:0]  AddrStatus = 8'h09;
  localparam logic [7:0]  AddrTimer  = 8'h0a;
  localparam logic [7:0]  AddrKey    = 8'h0b;
  localparam logic [7:0]  AddrWindow = 8'h0c;

  localparam logic [31:0] KeyFirst   = 32'h0000_00a5;
  localparam logic [31:0] KeySecond  = 32'h0000_005a;
  localparam logic [27:0] TimerReset = 28'h0ff_ffff;
  // Counter runs 0..15 while in StReset, giving a 16-cycle request.
  localparam logic [4:0]  ResetLast  = 5'd15;

  localparam logic [2:0]  StIdle  = 3'd0;
  localparam logic [2:0]  StArmed = 3'd1;
  localparam logic [2:0]  StKey1  = 3'd2;
  localparam logic [2:0]  StReset = 3'd3;
  localparam logic [2:0]  StHalt  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [4:0]  rst_cnt_q, rst_cnt_d;
  logic [27:0] timer_q, timer_d;
  logic        violation_q, violation_d;
  logic        timeout_q, timeout_d;
  logic        start_q, start_d;
  logic        stop_q, stop_d;
  logic        ready_q;
  logic [31:0] read_data_q, read_mux;
  logic [27:0] window_rd;
  logic        kick_ok;
  logic        wr_en;

`ifdef WATCHDOG_WINDOW_EN
  logic [27:0] window_q, window_d;
  logic [27:0] elapsed_q, elapsed_d;
`endif

  assign wr_en = cs & we;

  // Next-state logic. Timeout is tested before any write so it wins a tie.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    timer_d     = timer_q;
    violation_d = violation_q;
    timeout_d   = timeout_q;
    start_d     = 1'b0;
    stop_d      = 1'b0;
`ifdef WATCHDOG_WINDOW_EN
    window_d    = window_q;
`endif
    case (state_q)
      StIdle: begin
        if (wr_en) begin
          if (address == AddrCtrl && write_data[0]) begin
            start_d = 1'b1;
            state_d = StArmed;
          end else if (address == AddrTimer) begin
            timer_d = write_data[27:0];
          end
`ifdef WATCHDOG_WINDOW_EN
          else if (address == AddrWindow) begin
            window_d = write_data[27:0];
          end
`endif
        end
      end
      StArmed: begin
        if (core_timeout) begin
          timeout_d = 1'b1;
          state_d   = StReset;
          rst_cnt_d = 5'd0;
        end else if (wr_en && address == AddrKey) begin
          if (write_data == KeyFirst) begin
            state_d = StKey1;
          end else begin
            violation_d = 1'b1;
            state_d     = StReset;
            rst_cnt_d   = 5'd0;
          end
        end
      end
      StKey1: begin
        if (core_timeout) begin
          timeout_d = 1'b1;
          state_d   = StReset;
          rst_cnt_d = 5'd0;
        end else if (wr_en) begin
          // Only a (timely) second key or a stop request is legal here.
          if (address == AddrKey && write_data == KeySecond && kick_ok) begin
            start_d = 1'b1;
            state_d = StArmed;
          end else if (address == AddrCtrl && write_data[1]) begin
            stop_d  = 1'b1;
            state_d = StIdle;
          end else begin
            violation_d = 1'b1;
            state_d     = StReset;
            rst_cnt_d   = 5'd0;
          end
        end
      end
      StReset: begin
        if (rst_cnt_q == ResetLast) begin
          state_d = StHalt;
        end else begin
          rst_cnt_d = rst_cnt_q + 5'd1;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

`ifdef WATCHDOG_WINDOW_EN
  // Elapsed time since the last start/kick, saturating so a long wait never
  // wraps back into the forbidden window.
  always_comb begin
    elapsed_d = elapsed_q;
    if (start_d) begin
      elapsed_d = 28'd0;
    end else if ((state_q == StArmed || state_q == StKey1) && elapsed_q != '1) begin
      elapsed_d = elapsed_q + 28'd1;
    end
  end

  assign kick_ok   = (elapsed_q >= window_q);
  assign window_rd = window_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      window_q  <= 28'd0;
      elapsed_q <= 28'd0;
    end else begin
      window_q  <= window_d;
      elapsed_q <= elapsed_d;
    end
  end
`else
  assign kick_ok   = 1'b1;
  assign window_rd = 28'd0;
`endif

  always_comb begin
    read_mux = 32'h0;
    case (address)
      AddrStatus: read_mux = {27'h0, (state_q == StHalt), violation_q, timeout_q,
                              (state_q == StKey1), core_running};
      AddrTimer:  read_mux = {4'h0, timer_q};
      AddrWindow: read_mux = {4'h0, window_rd};
      default:    read_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      rst_cnt_q   <= 5'd0;
      timer_q     <= TimerReset;
      violation_q <= 1'b0;
      timeout_q   <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      ready_q     <= 1'b0;
      read_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      timer_q     <= timer_d;
      violation_q <= violation_d;
      timeout_q   <= timeout_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      ready_q     <= cs;
      // read_data holds the last read result between reads
      if (cs && !we) begin
        read_data_q <= read_mux;
      end
    end
  end

  assign read_data       = read_data_q;
  assign ready           = ready_q;
  assign core_start      = start_q;
  assign core_stop       = stop_q;
  assign core_timer_init = timer_q;
  assign sys_reset_req   = (state_q == StReset);

endmodule

// File: tb/tb_watchdog_ctrl.sv
// Self-checking bench for watchdog_ctrl: directed scenarios followed by a
// randomized register-access run, all checked against a transaction-level
// behavioural model of the watchdog rules.

module tb_watchdog_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        core_start;
  logic        core_stop;
  logic [27:0] core_timer_init;
  logic        core_running;
  logic        core_timeout;
  logic        sys_reset_req;

  watchdog_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cs              (cs),
    .we              (we),
    .address         (address),
    .write_data      (write_data),
    .read_data       (read_data),
    .ready           (ready),
    .core_start      (core_start),
    .core_stop       (core_stop),
    .core_timer_init (core_timer_init),
    .core_running    (core_running),
    .core_timeout    (core_timeout),
    .sys_reset_req   (sys_reset_req)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] ACtrl = 8'h08, AStatus = 8'h09, ATimer = 8'h0a;
  localparam logic [7:0] AKey = 8'h0b, AWindow = 8'h0c;

  int errors = 0;
  int checks = 0;

  // Behavioural model: abstract modes, reset duration as cycles remaining.
  localparam int MIdle = 0, MArmed = 1, MKey1 = 2, MResetting = 3, MHalted = 4;
  int          m_mode;
  int          m_left;
  logic [27:0] m_timer, m_window, m_elapsed;
  logic        m_viol, m_tmo, m_start, m_stop, m_ready;
  logic [31:0] m_rd;
  bit          rand_run = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = MIdle; m_left = 0;
    m_timer = 28'h0ffffff; m_window = 28'h0; m_elapsed = 28'h0;
    m_viol = 1'b0; m_tmo = 1'b0;
    m_start = 1'b0; m_stop = 1'b0; m_ready = 1'b0; m_rd = 32'h0;
  endfunction

  function automatic void model_enter_reset();
    m_mode = MResetting;
    m_left = 16;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a, input logic run);
    case (a)
      AStatus: return {27'h0, m_mode == MHalted, m_viol, m_tmo, m_mode == MKey1, run};
      ATimer:  return {4'h0, m_timer};
      AWindow: return {4'h0, m_window};
      default: return 32'h0;
    endcase
  endfunction

  // Applies one clock cycle's worth of bus activity to the model.
  function automatic void model_clock(input logic c, input logic w, input logic [7:0] a,
                                      input logic [31:0] d, input logic to, input logic run);
    logic wr;
    int   prev;
    bit   win_ok;
    wr     = c && w;
    prev   = m_mode;
    win_ok = 1'b1;
`ifdef WATCHDOG_WINDOW_EN
    win_ok = (m_elapsed >= m_window);
`endif
    m_ready = c;
    m_start = 1'b0;
    m_stop  = 1'b0;
    if (c && !w) m_rd = model_read(a, run);
    if (m_mode == MIdle) begin
      if (wr && a == ACtrl && d[0]) begin
        m_start = 1'b1; m_mode = MArmed;
      end else if (wr && a == ATimer) begin
        m_timer = d[27:0];
`ifdef WATCHDOG_WINDOW_EN
      end else if (wr && a == AWindow) begin
        m_window = d[27:0];
`endif
      end
    end else if (m_mode == MArmed || m_mode == MKey1) begin
      if (to) begin
        m_tmo = 1'b1; model_enter_reset();
      end else if (wr && m_mode == MArmed) begin
        if (a == AKey) begin
          if (d == 32'ha5) m_mode = MKey1;
          else begin m_viol = 1'b1; model_enter_reset(); end
        end
      end else if (wr) begin
        if (a == AKey && d == 32'h5a && win_ok) begin
          m_start = 1'b1; m_mode = MArmed;
        end else if (a == ACtrl && d[1]) begin
          m_stop = 1'b1; m_mode = MIdle;
        end else begin
          m_viol = 1'b1; model_enter_reset();
        end
      end
    end else if (m_mode == MResetting) begin
      m_left--;
      if (m_left == 0) m_mode = MHalted;
    end
    if (m_start) m_elapsed = 28'h0;
    else if ((prev == MArmed || prev == MKey1) && m_elapsed != 28'hfffffff) m_elapsed++;
  endfunction

  task automatic compare_all();
    check("ready", ready, m_ready);
    check("core_start", core_start, m_start);
    check("core_stop", core_stop, m_stop);
    check("start_stop_overlap", core_start & core_stop, 1'b0);
    check("sys_reset_req", sys_reset_req, m_mode == MResetting);
    check("read_data", read_data, m_rd);
    check("core_timer_init", core_timer_init, m_timer);
  endtask

  // One clock cycle; inputs change #1 after the rising edge, outputs sampled
  // #1 after the next one.
  task automatic cyc(input logic c, input logic w, input logic [7:0] a, input logic [31:0] d,
                     input logic to);
    cs = c; we = w; address = a; write_data = d; core_timeout = to;
    core_running = rand_run ? 1'($urandom_range(0, 1)) : 1'b0;
    model_clock(c, w, a, d, to, core_running);
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0; core_timeout = 1'b0;
    compare_all();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, a, d, 1'b0);
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    cyc(1'b1, 1'b0, a, 32'h0, 1'b0);
    check(tag, read_data, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; cs = 1'b0; we = 1'b0; core_timeout = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    compare_all();
  endtask

  // Counts sys_reset_req cycles, starting with the current sample.
  task automatic count_reset_pulse(output int n);
    n = sys_reset_req ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      idle(1);
      if (sys_reset_req) n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    int r;
    logic [31:0] d;
    logic [7:0]  a;
    cs = 1'b0; we = 1'b0; address = 8'h0; write_data = 32'h0;
    core_running = 1'b0; core_timeout = 1'b0; reset_n = 1'b0;
    @(posedge clk); #1;

    // Reset values and basic reads
    do_reset();
    check("reset_sys_reset_req", sys_reset_req, 1'b0);
    rd_check("status_after_reset", AStatus, 32'h0);
    rd_check("timer_after_reset", ATimer, 32'h0ffffff);
    idle(1);
    check("ready_idle_low", ready, 1'b0);
    rd_check("ctrl_reads_zero", ACtrl, 32'h0);
    wr(8'h20, 32'hffff_ffff);
    rd_check("unmapped_reads_zero", 8'h20, 32'h0);

    // Arm with TIMER=100, then let the core time out
    wr(ATimer, 32'd100);
    check("timer_init_100", core_timer_init, 28'd100);
    wr(ACtrl, 32'h1);
    check("arm_start_pulse", core_start, 1'b1);
    idle(1);
    check("arm_start_one_cycle", core_start, 1'b0);
    idle(3);
    cyc(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
    count_reset_pulse(n);
    check("timeout_reset_len", n, 16);
    rd_check("status_halt_timeout", AStatus, 32'h14);
    wr(ACtrl, 32'h1);
    check("halt_ignores_ctrl", core_start, 1'b0);

    // Kick sequence, then stop
    do_reset();
    wr(ACtrl, 32'h1);
    wr(AKey, 32'ha5);
    rd_check("status_key1", AStatus, 32'h02);
    wr(AKey, 32'h5a);
    check("kick_start_pulse", core_start, 1'b1);
    rd_check("status_after_kick", AStatus, 32'h0);
    wr(ACtrl, 32'h1);
    wr(ATimer, 32'd5);
    check("armed_ignores_timer", core_timer_init, 28'h0ffffff);
    wr(AKey, 32'ha5);
    wr(ACtrl, 32'h2);
    check("stop_pulse", core_stop, 1'b1);
    check("stop_no_start", core_start, 1'b0);
    wr(ATimer, 32'd7);
    check("idle_timer_write", core_timer_init, 28'd7);

    // Illegal write in KEY1
    wr(ACtrl, 32'h1);
    wr(AKey, 32'ha5);
    wr(ATimer, 32'h123);
    count_reset_pulse(n);
    check("violation_reset_len", n, 16);
    check("timer_unchanged", core_timer_init, 28'd7);
    rd_check("status_violation", AStatus, 32'h18);

    // Timeout coincident with the second key
    do_reset();
    wr(ACtrl, 32'h1);
    wr(AKey, 32'ha5);
    cyc(1'b1, 1'b1, AKey, 32'h5a, 1'b1);
    check("timeout_beats_kick", core_start, 1'b0);
    check("timeout_enters_reset", sys_reset_req, 1'b1);
    rd_check("status_timeout", AStatus, 32'h04);
    idle(3);
    // Reset in the middle of the request
    do_reset();
    check("midpulse_reset_drop", sys_reset_req, 1'b0);

    // Wrong first key
    wr(ACtrl, 32'h1);
    wr(AKey, 32'h1234);
    check("bad_key_reset", sys_reset_req, 1'b1);
    do_reset();

`ifdef WATCHDOG_WINDOW_EN
    wr(AWindow, 32'd50);
    rd_check("window_readback", AWindow, 32'd50);
    wr(ACtrl, 32'h1);
    idle(16);
    wr(AKey, 32'ha5);
    wr(AKey, 32'h5a);
    check("early_kick_violation", sys_reset_req, 1'b1);
    do_reset();
    wr(AWindow, 32'd50);
    wr(ACtrl, 32'h1);
    idle(58);
    wr(AKey, 32'ha5);
    wr(AKey, 32'h5a);
    check("late_kick_accepted", core_start, 1'b1);
    do_reset();
`else
    wr(AWindow, 32'd50);
    rd_check("window_disabled_zero", AWindow, 32'h0);
    wr(ACtrl, 32'h1);
    wr(AKey, 32'ha5);
    wr(AKey, 32'h5a);
    check("kick_always_ok", core_start, 1'b1);
    do_reset();
`endif

    // Randomized accesses against the model
    rand_run = 1;
    for (int i = 0; i < 800; i++) begin
      if (m_mode == MHalted && $urandom_range(0, 3) == 0) do_reset();
      r = $urandom_range(0, 11);
      d = $urandom();
      a = 8'($urandom_range(6, 14));
      case (r)
        0:  cyc(1'b1, 1'b1, AKey, 32'ha5, 1'($urandom_range(0, 19) == 0));
        1:  cyc(1'b1, 1'b1, AKey, 32'h5a, 1'($urandom_range(0, 19) == 0));
        2:  wr(AKey, d);
        3:  wr(ACtrl, 32'h1);
        4:  wr(ACtrl, 32'h2);
        5:  wr(ACtrl, d);
        6:  wr(ATimer, d);
        7:  wr(AWindow, 32'($urandom_range(0, 12)));
        8:  wr(a, d);
        9:  cyc(1'b1, 1'b0, a, 32'h0, 1'b0);
        10: idle($urandom_range(1, 4));
        default: cyc(1'b0, 1'b0, 8'h00, 32'h0, 1'($urandom_range(0, 3) == 0));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
